coin_dispenser: RTL and testbench

COIN_DISPENSER -- requirements
Module: coin_dispenser

---
 rtl/vending_pkg.sv | 43 ++++
 rtl/coin_select.sv | 26 ++
 rtl/coin_dispenser.sv | 109 ++++++++++
 tb/tb_coin_dispenser.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg
// Shared definitions for the vending datapath: money width, coin codes,
// coin values and the coin dispenser state encoding. Also used by
// mini_vending, so keep it free of anything dispenser-specific beyond
// the state enum.
package vending_pkg;

  // All money amounts (price, credit, change, remain) are 6-bit unsigned.
  localparam int MONEY_W = 6;

  // Coin codes as driven on coin_type.
  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_5  = 2'b01,
    COIN_10 = 2'b10,
    COIN_50 = 2'b11
  } coin_t;

  localparam logic [MONEY_W-1:0] VAL_1  = 6'd1;
  localparam logic [MONEY_W-1:0] VAL_5  = 6'd5;
  localparam logic [MONEY_W-1:0] VAL_10 = 6'd10;
  localparam logic [MONEY_W-1:0] VAL_50 = 6'd50;

  // Dispenser FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Face value of a coin code.
  function automatic logic [MONEY_W-1:0] coin_value(input coin_t c);
    logic [MONEY_W-1:0] v;
    case (c)
      COIN_50: v = VAL_50;
      COIN_10: v = VAL_10;
      COIN_5:  v = VAL_5;
      default: v = VAL_1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// coin_select
// Purely combinational greedy coin picker: returns the largest coin whose
// value does not exceed the remaining amount.
// Ports:
//   remain     - amount still to be paid out
//   coin_type  - code of the selected coin
//   coin_val   - face value of the selected coin
// With remain == 0 the 1-unit coin is reported; callers only use the
// result while remain != 0, so the selection never exceeds remain.
module coin_select
  import vending_pkg::*;
(
  input  logic [MONEY_W-1:0] remain,
  output coin_t              coin_type,
  output logic [MONEY_W-1:0] coin_val
);

  always_comb begin
    if (remain >= VAL_50)      coin_type = COIN_50;
    else if (remain >= VAL_10) coin_type = COIN_10;
    else if (remain >= VAL_5)  coin_type = COIN_5;
    else                       coin_type = COIN_1;
    coin_val = coin_value(coin_type);
  end

endmodule

// File: rtl/coin_dispenser.sv
// coin_dispenser
// Pays out change as a sequence of coins, greedy largest-first, over a
// valid/ready handshake to the coin hopper.
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   start       - change-ready strobe, sampled only in IDLE
//   change      - amount to return, latched with start
//   coin_ready  - hopper accepts the offered coin this cycle
//   coin_valid  - a coin is offered on coin_type
//   coin_type   - offered coin code (00=1, 01=5, 10=10, 11=50)
//   busy        - transaction in progress (DISP or DONE)
//   done        - one-cycle pulse at the end of a transaction
//   coin_cnt    - coins handed over in the current/last transaction
//   fsm_state   - current FSM state, for observation only
//
// Handshake: a coin transfers on a rising edge where coin_valid and
// coin_ready are both 1. While coin_valid is 1 and coin_ready is 0,
// coin_valid and coin_type hold their values (remain does not change, so
// the greedy selection cannot move). coin_valid never drops without a
// transfer except on reset.
module coin_dispenser
  import vending_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MONEY_W-1:0] change,
  input  logic               coin_ready,
  output logic               coin_valid,
  output logic [1:0]         coin_type,
  output logic               busy,
  output logic               done,
  output logic [3:0]         coin_cnt,
  output state_t             fsm_state
);

  state_t             state_q, state_d;
  logic [MONEY_W-1:0] remain_q;
  logic [3:0]         cnt_q;
  coin_t              sel_type;
  logic [MONEY_W-1:0] sel_val;
  logic               xfer;

  coin_select u_sel (
    .remain    (remain_q),
    .coin_type (sel_type),
    .coin_val  (sel_val)
  );

  assign xfer = (state_q == DISP) && coin_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (change == '0) ? DONE : DISP;
      // The last coin is the one whose value equals what is left.
      DISP: if (coin_ready && (remain_q == sel_val)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remain and coin count. Subtraction cannot wrap: the greedy pick is
  // always <= remain while in DISP (remain is nonzero there).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain_q <= '0;
      cnt_q    <= '0;
    end else if ((state_q == IDLE) && start) begin
      remain_q <= change;
      cnt_q    <= '0;
    end else if (xfer) begin
      remain_q <= remain_q - sel_val;
      cnt_q    <= cnt_q + 4'd1;
    end
  end

  // Outputs decoded from state; reset forces state to IDLE so all of
  // these drop immediately on rst.
  always_comb begin
    coin_valid = 1'b0;
    coin_type  = 2'b00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      DISP: begin
        coin_valid = 1'b1;
        coin_type  = sel_type;
        busy       = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign coin_cnt  = cnt_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// tb_coin_dispenser
// Directed scenarios for coin_dispenser. The driver pushes each expected
// event (coin with its cycle, or done with final count and cycle) into
// exp_q; the monitor pops on every coin transfer and every done pulse.
module tb_coin_dispenser;
  import vending_pkg::*;

  // Entry layout: {is_done, coin_type[1:0], coin_cnt[3:0], cycle[16:0]}
  localparam int W = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] change = 6'd0;
  logic       coin_ready = 1'b0;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       busy;
  logic       done;
  logic [3:0] coin_cnt;
  state_t     fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];

  logic       prev_stall = 1'b0;
  logic [1:0] prev_type  = 2'b00;

  coin_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .change     (change),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .busy       (busy),
    .done       (done),
    .coin_cnt   (coin_cnt),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic d, input logic [1:0] t,
                                      input logic [3:0] n, input int c);
    logic [16:0] cc;
    cc = c[16:0];
    return {d, t, n, cc};
  endfunction

  task automatic push_coin(input logic [1:0] t, input int c);
    exp_q.push_back(mk(1'b0, t, 4'd0, c));
  endtask

  task automatic push_done(input logic [3:0] n, input int c);
    exp_q.push_back(mk(1'b1, 2'b00, n, c));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [5:0] ch, output int c);
    @(posedge clk); #1;
    start  = 1'b1;
    change = ch;
    c      = cyc;
  endtask

  task automatic end_start();
    @(posedge clk); #1;
    start  = 1'b0;
    change = 6'($urandom_range(0, 63));
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("txn_complete", {31'd0, ok}, 32'd1);
    exp_q.delete();
  endtask

  task automatic check_idle(input logic [3:0] n);
    repeat (2) @(posedge clk);
    #2;
    check("idle_coin_cnt", coin_cnt, n);
    check("idle_coin_valid", coin_valid, 0);
    check("idle_state", fsm_state, IDLE);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_step();
    logic [W-1:0] e;
    check("busy", busy, coin_valid | done);
    if (prev_stall) begin
      check("stall_valid_held", coin_valid, 1);
      check("stall_type_held", coin_type, prev_type);
    end
    if (coin_valid && coin_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_coin", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("coin_not_done", 0, e[23]);
        check("coin_type", coin_type, e[22:21]);
        check("coin_cycle", cyc, e[16:0]);
      end
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_not_coin", 1, e[23]);
        check("done_coin_cnt", coin_cnt, e[20:17]);
        check("done_cycle", cyc, e[16:0]);
      end
    end
    prev_stall = coin_valid && !coin_ready;
    prev_type  = coin_type;
  endtask

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else     monitor_step();
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;

    #1 rst = 1'b1;
    #1;
    check("rst_coin_valid", coin_valid, 0);
    check("rst_coin_type", coin_type, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coin_cnt", coin_cnt, 0);
    check("rst_state", fsm_state, IDLE);
    coin_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // change=15: 10, 5; done 3 cycles after start
    do_start(6'd15, c);
    push_coin(2'b10, c + 1);
    push_coin(2'b01, c + 2);
    push_done(4'd2, c + 3);
    end_start();
    wait_idle(20);
    check_idle(4'd2);

    // change=37: 10,10,10,5,1,1; done 7 cycles after start
    do_start(6'd37, c);
    push_coin(2'b10, c + 1);
    push_coin(2'b10, c + 2);
    push_coin(2'b10, c + 3);
    push_coin(2'b01, c + 4);
    push_coin(2'b00, c + 5);
    push_coin(2'b00, c + 6);
    push_done(4'd6, c + 7);
    end_start();
    wait_idle(20);
    check_idle(4'd6);

    // change=0: no coins, done next cycle
    do_start(6'd0, c);
    push_done(4'd0, c + 1);
    end_start();
    wait_idle(20);
    check_idle(4'd0);

    // change=63 with hopper stalled 3 cycles on the first coin
    coin_ready = 1'b0;
    do_start(6'd63, c);
    push_coin(2'b11, c + 4);
    push_coin(2'b10, c + 5);
    push_coin(2'b00, c + 6);
    push_coin(2'b00, c + 7);
    push_coin(2'b00, c + 8);
    push_done(4'd5, c + 9);
    end_start();
    repeat (3) begin
      @(posedge clk); #1;
    end
    coin_ready = 1'b1;
    wait_idle(30);
    check_idle(4'd5);

    // change=49 with a stray start(5) while dispensing
    do_start(6'd49, c);
    for (int k = 1; k <= 4; k++) push_coin(2'b10, c + k);
    push_coin(2'b01, c + 5);
    for (int k = 6; k <= 9; k++) push_coin(2'b00, c + k);
    push_done(4'd9, c + 10);
    end_start();
    @(posedge clk); #1;
    start  = 1'b1;
    change = 6'd5;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_idle(30);
    check_idle(4'd9);

    // change=37 aborted by reset after the 2nd coin
    do_start(6'd37, c);
    push_coin(2'b10, c + 1);
    push_coin(2'b10, c + 2);
    end_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_coin_valid", coin_valid, 0);
    check("abort_coin_type", coin_type, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_coin_cnt", coin_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // change=13 after reset: 10,1,1,1
    do_start(6'd13, c);
    push_coin(2'b10, c + 1);
    push_coin(2'b00, c + 2);
    push_coin(2'b00, c + 3);
    push_coin(2'b00, c + 4);
    push_done(4'd4, c + 5);
    end_start();
    wait_idle(20);
    check_idle(4'd4);

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
